ram1_bus_arbiter: RTL and testbench

Arbitrates the single RAM1 SRAM/COM1 UART bus between instruction fetch (IF) and the data-memory stage (MEM). It sequences multi-cycle SRAM and UART transactions and drives the shared RAM1 pins and UART strobes. It raises a pipeline stall while any accepted request is unfinished. It sits between the IF/MEM pipeline stages and the board's RAM1 and UART pins. RAM2 is outside its scope.

---
 rtl/ram1_bus_arbiter_pkg.sv | 53 +++++
 rtl/ram1_addr_decode.sv | 25 ++
 rtl/ram1_bus_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_ram1_bus_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram1_bus_arbiter_pkg.sv
// Shared definitions for the RAM1/COM1 bus arbiter: address map, FSM states, request kinds.
// No logic; combinational helper only.
// No flow control of its own.
package ram1_bus_arbiter_pkg;

    localparam logic [15:0] RAM1_UPPER   = 16'h8000;
    localparam logic [15:0] COM1_DATA    = 16'hBF00;
    localparam logic [15:0] COM1_COMMAND = 16'hBF01;

    // Wait states exist in every build; they are only entered when RAM1_WAIT_EN is defined.
    typedef enum logic [3:0] {
        IDLE,
        SR_ADDR,
        SR_WAIT,
        SR_DATA,
        SW_ADDR,
        SW_WAIT,
        SW_HOLD,
        FETCH_ADDR,
        FETCH_WAIT,
        FETCH_DATA,
        UR_STB,
        UR_WAIT,
        UR_DONE,
        UW_STB,
        UW_WAIT,
        US_RD
    } state_t;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_RD,
        REQ_WR,
        REQ_BAD
    } req_kind_t;

    typedef enum logic [1:0] {
        ADDR_RAM1,
        ADDR_UART_DATA,
        ADDR_UART_STATUS,
        ADDR_OTHER
    } addr_class_t;

    function automatic req_kind_t req_kind(input logic rd, input logic wr);
        case ({rd, wr})
            2'b10:   return REQ_RD;
            2'b01:   return REQ_WR;
            2'b11:   return REQ_BAD;
            default: return REQ_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ram1_addr_decode.sv
// Classifies a 16-bit address as RAM1, UART data, UART status or other.
// Latency: purely combinational.
// Backpressure: none.
import ram1_bus_arbiter_pkg::*;

module ram1_addr_decode #(
    parameter logic [15:0] RAM1_UPPER   = ram1_bus_arbiter_pkg::RAM1_UPPER,
    parameter logic [15:0] COM1_DATA    = ram1_bus_arbiter_pkg::COM1_DATA,
    parameter logic [15:0] COM1_COMMAND = ram1_bus_arbiter_pkg::COM1_COMMAND
) (
    input  logic [15:0]  addr,
    output addr_class_t  addr_class
);

    always_comb begin
        addr_class = ADDR_OTHER;
        if (addr < RAM1_UPPER)
            addr_class = ADDR_RAM1;
        else if (addr == COM1_DATA)
            addr_class = ADDR_UART_DATA;
        else if (addr == COM1_COMMAND)
            addr_class = ADDR_UART_STATUS;
    end

endmodule

// File: rtl/ram1_bus_arbiter.sv
// Arbitrates the shared RAM1 SRAM / COM1 UART bus between instruction fetch and MEM stage.
// Latency: SRAM 2 cycles (3 with RAM1_WAIT_EN), UART status 1, UART read/write wait on UART flags.
// Backpressure: stall held while any accepted request is unfinished; MEM wins arbitration in IDLE.
import ram1_bus_arbiter_pkg::*;

module ram1_bus_arbiter #(
    parameter logic [15:0] RAM1_UPPER   = ram1_bus_arbiter_pkg::RAM1_UPPER,
    parameter logic [15:0] COM1_DATA    = ram1_bus_arbiter_pkg::COM1_DATA,
    parameter logic [15:0] COM1_COMMAND = ram1_bus_arbiter_pkg::COM1_COMMAND
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_instr,
    output logic        if_valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_done,
    output logic        stall,
    inout  wire  [15:0] ram1_data,
    output logic [17:0] ram1_addr,
    output logic        ram1_en,
    output logic        ram1_oe,
    output logic        ram1_we,
    output logic        uart_rdn,
    output logic        uart_wrn,
    input  logic        uart_data_ready,
    input  logic        uart_tbre,
    input  logic        uart_tsre
);

    state_t      state;
    state_t      next_state;
    addr_class_t mem_cls;
    req_kind_t   mem_kind;
    logic        mem_hit;
    logic        ur_cnt;
    logic        uart_tx_idle;
    logic        bus_oe;
    logic [15:0] bus_dout;

    ram1_addr_decode #(
        .RAM1_UPPER   (RAM1_UPPER),
        .COM1_DATA    (COM1_DATA),
        .COM1_COMMAND (COM1_COMMAND)
    ) u_decode (
        .addr       (mem_addr),
        .addr_class (mem_cls)
    );

    // Simultaneous rd and wr is illegal; treating it as no request keeps the bus quiet.
    assign mem_kind     = req_kind(mem_rd, mem_wr);
    assign mem_hit      = ((mem_kind == REQ_RD) || (mem_kind == REQ_WR)) && (mem_cls != ADDR_OTHER);
    assign uart_tx_idle = uart_tbre & uart_tsre;

    assign ram1_data = bus_oe ? bus_dout : 16'hzzzz;
    assign stall     = ((state != IDLE) || mem_hit || if_req) && !(mem_done || if_valid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ram1_en    = 1'b1;
        ram1_oe    = 1'b1;
        ram1_we    = 1'b1;
        uart_rdn   = 1'b1;
        uart_wrn   = 1'b1;
        bus_oe     = 1'b0;
        bus_dout   = mem_wdata;
        if_valid   = 1'b0;
        mem_done   = 1'b0;
        case (state)
            IDLE: begin
                if (mem_hit) begin
                    case (mem_cls)
                        ADDR_RAM1:      next_state = (mem_kind == REQ_RD) ? SR_ADDR : SW_ADDR;
                        ADDR_UART_DATA: next_state = (mem_kind == REQ_RD) ? UR_STB : UW_STB;
                        default:        next_state = US_RD;
                    endcase
                end else if (if_req) begin
                    next_state = FETCH_ADDR;
                end
            end
            SR_ADDR: begin
                ram1_en = 1'b0;
                ram1_oe = 1'b0;
`ifdef RAM1_WAIT_EN
                next_state = SR_WAIT;
`else
                next_state = SR_DATA;
`endif
            end
            SR_WAIT: begin
                ram1_en    = 1'b0;
                ram1_oe    = 1'b0;
                next_state = SR_DATA;
            end
            SR_DATA: begin
                mem_done   = 1'b1;
                next_state = IDLE;
            end
            SW_ADDR: begin
                ram1_en = 1'b0;
                ram1_we = 1'b0;
                bus_oe  = 1'b1;
`ifdef RAM1_WAIT_EN
                next_state = SW_WAIT;
`else
                next_state = SW_HOLD;
`endif
            end
            SW_WAIT: begin
                ram1_en    = 1'b0;
                ram1_we    = 1'b0;
                bus_oe     = 1'b1;
                next_state = SW_HOLD;
            end
            SW_HOLD: begin
                // Data stays on the bus past the rising edge of we.
                bus_oe     = 1'b1;
                mem_done   = 1'b1;
                next_state = IDLE;
            end
            FETCH_ADDR: begin
                ram1_en = 1'b0;
                ram1_oe = 1'b0;
`ifdef RAM1_WAIT_EN
                next_state = FETCH_WAIT;
`else
                next_state = FETCH_DATA;
`endif
            end
            FETCH_WAIT: begin
                ram1_en    = 1'b0;
                ram1_oe    = 1'b0;
                next_state = FETCH_DATA;
            end
            FETCH_DATA: begin
                if_valid   = 1'b1;
                next_state = IDLE;
            end
            UR_STB: begin
                if (uart_data_ready)
                    next_state = UR_WAIT;
            end
            UR_WAIT: begin
                uart_rdn = 1'b0;
                if (ur_cnt)
                    next_state = UR_DONE;
            end
            UR_DONE: begin
                mem_done   = 1'b1;
                next_state = IDLE;
            end
            UW_STB: begin
                bus_oe     = 1'b1;
                bus_dout   = {8'h00, mem_wdata[7:0]};
                uart_wrn   = 1'b0;
                next_state = UW_WAIT;
            end
            UW_WAIT: begin
                bus_oe   = 1'b1;
                bus_dout = {8'h00, mem_wdata[7:0]};
                if (uart_tx_idle) begin
                    mem_done   = 1'b1;
                    next_state = IDLE;
                end
            end
            US_RD: begin
                mem_done   = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ur_cnt    <= 1'b0;
            ram1_addr <= 18'h0;
            if_instr  <= 16'h0;
            mem_rdata <= 16'h0;
        end else begin
            // Two-cycle rdn strobe: low for ur_cnt = 0 then 1.
            ur_cnt <= (state == UR_WAIT) ? ~ur_cnt : 1'b0;
            if (state == IDLE) begin
                if (next_state == FETCH_ADDR)
                    ram1_addr <= {2'b00, if_addr};
                else if ((next_state == SR_ADDR) || (next_state == SW_ADDR))
                    ram1_addr <= {2'b00, mem_addr};
            end
            if (next_state == FETCH_DATA)
                if_instr <= ram1_data;
            if (next_state == SR_DATA)
                mem_rdata <= ram1_data;
            if (next_state == UR_DONE)
                mem_rdata <= {8'h00, ram1_data[7:0]};
            // A write to the status register completes with no side effect.
            if ((state == IDLE) && (next_state == US_RD) && (mem_kind == REQ_RD))
                mem_rdata <= {14'b0, uart_data_ready, uart_tx_idle};
        end
    end

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// Directed bench for ram1_bus_arbiter with a small SRAM model and a UART read-data model.
module tb_ram1_bus_arbiter;

    localparam int OP_IF = 0;
    localparam int OP_RD = 1;
    localparam int OP_WR = 2;
`ifdef RAM1_WAIT_EN
    localparam int SRAM_LAT = 3;
`else
    localparam int SRAM_LAT = 2;
`endif
    localparam logic [15:0] UART_RX = 16'hA55A;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_instr;
    logic        if_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        stall;
    wire  [15:0] ram1_data;
    logic [17:0] ram1_addr;
    logic        ram1_en;
    logic        ram1_oe;
    logic        ram1_we;
    logic        uart_rdn;
    logic        uart_wrn;
    logic        uart_data_ready;
    logic        uart_tbre;
    logic        uart_tsre;

    always #5 clk = ~clk;

    ram1_bus_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_instr        (if_instr),
        .if_valid        (if_valid),
        .mem_rd          (mem_rd),
        .mem_wr          (mem_wr),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_done        (mem_done),
        .stall           (stall),
        .ram1_data       (ram1_data),
        .ram1_addr       (ram1_addr),
        .ram1_en         (ram1_en),
        .ram1_oe         (ram1_oe),
        .ram1_we         (ram1_we),
        .uart_rdn        (uart_rdn),
        .uart_wrn        (uart_wrn),
        .uart_data_ready (uart_data_ready),
        .uart_tbre       (uart_tbre),
        .uart_tsre       (uart_tsre)
    );

    // SRAM model indexed by the low address byte; UART returns a fixed byte on rdn.
    logic [15:0] sram [256];
    logic        sram_init = 1'b0;

    assign ram1_data = (!ram1_en && !ram1_oe) ? sram[ram1_addr[7:0]] :
                       (!uart_rdn ? UART_RX : 16'hzzzz);

    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < 256; i++) sram[i] <= 16'h0000;
            sram[8'h00] <= 16'h1111;
            sram[8'h10] <= 16'h6801;
            sram[8'h30] <= 16'h5555;
            sram_init   <= 1'b1;
        end else if (!ram1_en && !ram1_we) begin
            sram[ram1_addr[7:0]] <= ram1_data;
        end
    end

    int n_vec = 0;
    int n_bad = 0;
    int viol  = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (!ram1_we && !ram1_oe) viol++;
            if (!uart_rdn && !uart_wrn) viol++;
            if (!ram1_en && (!uart_rdn || !uart_wrn)) viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          cnt_we, cnt_wrn, cnt_rdn, stall_bad;
    logic [15:0] wrn_bus, hold_bus;

    // Drives one request after a rising edge, samples on falling edges, drops it in the done cycle.
    task automatic run_txn(input int op, input logic [15:0] addr, input logic [15:0] wdata,
                           output int lat, output logic [15:0] data);
        logic pwe;
        logic dn;
        @(posedge clk);
        #1;
        cnt_we = 0; cnt_wrn = 0; cnt_rdn = 0; stall_bad = 0;
        wrn_bus = 16'h0; hold_bus = 16'h0;
        lat = -1; data = 16'h0; pwe = 1'b1;
        case (op)
            OP_IF:   begin if_req = 1'b1; if_addr = addr; end
            OP_RD:   begin mem_rd = 1'b1; mem_addr = addr; end
            default: begin mem_wr = 1'b1; mem_addr = addr; mem_wdata = wdata; end
        endcase
        @(negedge clk);
        if (!stall) stall_bad++;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (!ram1_we) cnt_we++;
            if (!pwe && ram1_we) hold_bus = ram1_data;
            pwe = ram1_we;
            if (!uart_wrn) begin cnt_wrn++; wrn_bus = ram1_data; end
            if (!uart_rdn) cnt_rdn++;
            dn = (op == OP_IF) ? if_valid : mem_done;
            if (dn) begin
                lat  = c;
                data = (op == OP_IF) ? if_instr : mem_rdata;
                if (stall) stall_bad++;
                break;
            end
            if (!stall) stall_bad++;
        end
        if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    typedef struct {
        int          op;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rdy;
        logic        tbre;
        logic        tsre;
        logic        chk_data;
        logic [15:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t        vt [13];
    int          lat;
    logic [15:0] data;
    int          dn_c, iv_c, bad;
    logic [15:0] md, fi, smap, exp_map;

    initial begin
        vt[0]  = '{OP_WR, 16'h0020, 16'hBEEF, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, SRAM_LAT};
        vt[1]  = '{OP_RD, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, SRAM_LAT};
        vt[2]  = '{OP_IF, 16'h0010, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h6801, SRAM_LAT};
        vt[3]  = '{OP_WR, 16'h7FFF, 16'h1234, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, SRAM_LAT};
        vt[4]  = '{OP_RD, 16'h7FFF, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, SRAM_LAT};
        vt[5]  = '{OP_RD, 16'hBF01, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1};
        vt[6]  = '{OP_RD, 16'hBF01, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1};
        vt[7]  = '{OP_RD, 16'hBF01, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0002, 1};
        vt[8]  = '{OP_RD, 16'hBF01, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0001, 1};
        vt[9]  = '{OP_RD, 16'hBF00, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h005A, 4};
        vt[10] = '{OP_WR, 16'hBF00, 16'h1241, 1'b1, 1'b1, 1'b1, 1'b1, 16'h005A, 2};
        vt[11] = '{OP_WR, 16'hBF01, 16'hABCD, 1'b1, 1'b1, 1'b1, 1'b1, 16'h005A, 1};
        vt[12] = '{OP_IF, 16'h0020, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'hBEEF, SRAM_LAT};

        rst = 1'b0; if_req = 1'b0; if_addr = 16'h0; mem_rd = 1'b0; mem_wr = 1'b0;
        mem_addr = 16'h0; mem_wdata = 16'h0;
        uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_strobes", {27'h0, ram1_en, ram1_oe, ram1_we, uart_rdn, uart_wrn}, 32'h1F);
        chk("rst_addr", {14'h0, ram1_addr}, 32'h0);
        chk("rst_pulses", {30'h0, if_valid, mem_done}, 32'h0);
        chk("rst_if_instr", {16'h0, if_instr}, 32'h0);
        chk("rst_mem_rdata", {16'h0, mem_rdata}, 32'h0);
        chk("rst_stall", {31'h0, stall}, 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 13; i++) begin
            uart_data_ready = vt[i].rdy; uart_tbre = vt[i].tbre; uart_tsre = vt[i].tsre;
            run_txn(vt[i].op, vt[i].addr, vt[i].wdata, lat, data);
            chk($sformatf("v%0d_lat", i), lat, vt[i].exp_lat);
            chk($sformatf("v%0d_stall", i), stall_bad, 0);
            if (vt[i].chk_data)
                chk($sformatf("v%0d_data", i), {16'h0, data}, {16'h0, vt[i].exp_data});
        end
        uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;

        // MEM and IF requested together: MEM first, fetch follows through IDLE.
        @(posedge clk);
        #1;
        if_req = 1'b1; if_addr = 16'h0010; mem_rd = 1'b1; mem_addr = 16'h4000;
        dn_c = -1; iv_c = -1; smap = 16'h0; md = 16'h0; fi = 16'h0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (stall) smap[c] = 1'b1;
            if (mem_done) begin dn_c = c; md = mem_rdata; mem_rd = 1'b0; end
            if (if_valid) begin iv_c = c; fi = if_instr; if_req = 1'b0; break; end
        end
        if_req = 1'b0; mem_rd = 1'b0;
        exp_map = 16'h0;
        for (int c = 0; c <= 2 * SRAM_LAT + 1; c++)
            if (c != SRAM_LAT && c != 2 * SRAM_LAT + 1) exp_map[c] = 1'b1;
        chk("arb_mem_done_cycle", dn_c, SRAM_LAT);
        chk("arb_if_valid_cycle", iv_c, 2 * SRAM_LAT + 1);
        chk("arb_mem_rdata", {16'h0, md}, 32'h1111);
        chk("arb_if_instr", {16'h0, fi}, 32'h6801);
        chk("arb_stall_map", {16'h0, smap}, {16'h0, exp_map});

        // SRAM write strobe width and data hold past we rising.
        run_txn(OP_WR, 16'h0040, 16'h1357, lat, data);
        chk("sw_we_cycles", cnt_we, SRAM_LAT - 1);
        chk("sw_hold_data", {16'h0, hold_bus}, 32'h1357);
        run_txn(OP_RD, 16'h0040, 16'h0, lat, data);
        chk("sw_readback", {16'h0, data}, 32'h1357);

        // UART write with transmitter busy for five cycles.
        uart_tbre = 1'b0; uart_tsre = 1'b0;
        fork
            run_txn(OP_WR, 16'hBF00, 16'h1241, lat, data);
            begin repeat (6) @(posedge clk); #1; uart_tbre = 1'b1; uart_tsre = 1'b1; end
        join
        chk("uw_lat", lat, 5);
        chk("uw_wrn_pulses", cnt_wrn, 1);
        chk("uw_bus", {16'h0, wrn_bus}, 32'h0041);

        // UART read waiting for data_ready.
        uart_data_ready = 1'b0;
        fork
            run_txn(OP_RD, 16'hBF00, 16'h0, lat, data);
            begin repeat (4) @(posedge clk); #1; uart_data_ready = 1'b1; end
        join
        chk("ur_lat", lat, 6);
        chk("ur_rdn_cycles", cnt_rdn, 2);
        chk("ur_data", {16'h0, data}, 32'h005A);

        // Reset asserted in the middle of an SRAM write.
        @(posedge clk);
        #1;
        mem_wr = 1'b1; mem_addr = 16'h0030; mem_wdata = 16'hDEAD;
        @(posedge clk);
        #2;
        chk("rw_we_low_before", {31'h0, ram1_we}, 32'h0);
        rst = 1'b0;
        #1;
        chk("rw_en_we_released", {30'h0, ram1_en, ram1_we}, 32'h3);
        chk("rw_no_done", {31'h0, mem_done}, 32'h0);
        chk("rw_rdata_cleared", {16'h0, mem_rdata}, 32'h0);
        @(negedge clk);
        mem_wr = 1'b0;
        rst = 1'b1;
        run_txn(OP_RD, 16'h0030, 16'h0, lat, data);
        chk("rw_fresh_lat", lat, SRAM_LAT);
        chk("rw_abandoned_write", {16'h0, data}, 32'h5555);

        // Out-of-region requests are ignored.
        @(posedge clk);
        #1;
        bad = 0;
        mem_rd = 1'b1; mem_addr = 16'h8000;
        repeat (4) begin
            @(negedge clk);
            if (stall || mem_done || !ram1_en) bad++;
        end
        mem_rd = 1'b0; mem_wr = 1'b1; mem_addr = 16'hBF02;
        repeat (4) begin
            @(negedge clk);
            if (stall || mem_done || !uart_wrn) bad++;
        end
        mem_wr = 1'b0;
        chk("out_of_region", bad, 0);

        chk("strobe_overlap", viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
